// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler
//
// Shares one non-pipelined functional unit among NUM_RS reservation stations.
// A ready station is picked round-robin and its operand packet is latched. The FU
// is started one cycle later. The FU result is held and broadcast on the CDB
// until a grant arrives. A new op may issue in the same cycle as the CDB grant.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   flush             squash the in-flight op and return to idle
//   rs_ready          per-station insn_ready
//   rs_func/v1/v2/dst per-station packet, flattened (station i at [i*W +: W])
//   rs_issue          one-hot issue pulse to the selected station (combinational)
//   fu_start          one-cycle FU start pulse, cycle after issue
//   fu_func/v1/v2     latched packet presented to the FU
//   fu_done/result    FU completion pulse and result
//   cdb_req/tag/value CDB broadcast request and payload
//   cdb_grant         CDB grant, broadcast completes in that cycle
//   busy              scheduler not idle

module fu_issue_scheduler #(
  parameter int unsigned NUM_RS   = 4,
  parameter int unsigned RS_IDX_W = 2,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned FUNC_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_RS-1:0]          rs_ready,
  input  logic [NUM_RS*FUNC_W-1:0]   rs_func,
  input  logic [NUM_RS*DATA_W-1:0]   rs_v1,
  input  logic [NUM_RS*DATA_W-1:0]   rs_v2,
  input  logic [NUM_RS*TAG_W-1:0]    rs_dst,
  output logic [NUM_RS-1:0]          rs_issue,
  output logic                       fu_start,
  output logic [FUNC_W-1:0]          fu_func,
  output logic [DATA_W-1:0]          fu_v1,
  output logic [DATA_W-1:0]          fu_v2,
  input  logic                       fu_done,
  input  logic [DATA_W-1:0]          fu_result,
  output logic                       cdb_req,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  input  logic                       cdb_grant,
  output logic                       busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } state_e;

  state_e              state_q;
  logic [RS_IDX_W-1:0] rr_ptr_q;
  logic                fu_start_q;
  logic                cdb_req_q;
  logic                busy_q;
  logic [FUNC_W-1:0]   fu_func_q;
  logic [DATA_W-1:0]   fu_v1_q;
  logic [DATA_W-1:0]   fu_v2_q;
  logic [TAG_W-1:0]    dst_q;
  logic [TAG_W-1:0]    cdb_tag_q;
  logic [DATA_W-1:0]   cdb_value_q;

  // Per-station views of the flattened packet buses.
  logic [FUNC_W-1:0] func_arr [NUM_RS];
  logic [DATA_W-1:0] v1_arr   [NUM_RS];
  logic [DATA_W-1:0] v2_arr   [NUM_RS];
  logic [TAG_W-1:0]  dst_arr  [NUM_RS];

  for (genvar i = 0; i < NUM_RS; i++) begin : g_unpack
    assign func_arr[i] = rs_func[i*FUNC_W +: FUNC_W];
    assign v1_arr[i]   = rs_v1[i*DATA_W +: DATA_W];
    assign v2_arr[i]   = rs_v2[i*DATA_W +: DATA_W];
    assign dst_arr[i]  = rs_dst[i*TAG_W +: TAG_W];
  end

  // Round-robin search: first ready station at or after rr_ptr_q, wrapping.
  logic                sel_found;
  logic [RS_IDX_W-1:0] sel_idx;
  logic [RS_IDX_W-1:0] cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      cand = RS_IDX_W'((32'(rr_ptr_q) + k) % NUM_RS);
      if (!sel_found && rs_ready[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  logic [RS_IDX_W-1:0] rr_next;
  assign rr_next = RS_IDX_W'((32'(sel_idx) + 1) % NUM_RS);

  // Issue is possible from idle, or from writeback in the grant cycle so the FU
  // never sits empty while the CDB hands over.
  logic issue_slot;
  logic issue_fire;

  assign issue_slot = (state_q == StIdle) || ((state_q == StWb) && cdb_grant);
  assign issue_fire = !reset && !flush && sel_found && issue_slot;

  always_comb begin
    rs_issue = '0;
    if (issue_fire) begin
      rs_issue[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      fu_start_q  <= 1'b0;
      cdb_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      fu_func_q   <= '0;
      fu_v1_q     <= '0;
      fu_v2_q     <= '0;
      dst_q       <= '0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else if (flush) begin
      // Abandon whatever is in flight; pointer and data registers are kept.
      state_q    <= StIdle;
      fu_start_q <= 1'b0;
      cdb_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fu_start_q <= 1'b0;

      if (issue_fire) begin
        fu_func_q  <= func_arr[sel_idx];
        fu_v1_q    <= v1_arr[sel_idx];
        fu_v2_q    <= v2_arr[sel_idx];
        dst_q      <= dst_arr[sel_idx];
        rr_ptr_q   <= rr_next;
        fu_start_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (issue_fire) begin
            state_q <= StExec;
            busy_q  <= 1'b1;
          end
        end

        StExec: begin
          // fu_done may coincide with the fu_start pulse; it is captured here too.
          if (fu_done) begin
            cdb_tag_q   <= dst_q;
            cdb_value_q <= fu_result;
            state_q     <= StWb;
            cdb_req_q   <= 1'b1;
          end
        end

        StWb: begin
          if (cdb_grant) begin
            cdb_req_q <= 1'b0;
            if (issue_fire) begin
              state_q <= StExec;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q   <= StIdle;
          cdb_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign fu_start  = fu_start_q;
  assign fu_func   = fu_func_q;
  assign fu_v1     = fu_v1_q;
  assign fu_v2     = fu_v2_q;
  assign cdb_req   = cdb_req_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Testbench for fu_issue_scheduler: directed scenarios plus a randomized run
// checked against a rule-level reference model.

module tb_fu_issue_scheduler;

  localparam int N        = 4;
  localparam int RS_IDX_W = 2;
  localparam int TAG_W    = 6;
  localparam int DATA_W   = 32;
  localparam int FUNC_W   = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [N-1:0]          rs_ready;
  logic [N*FUNC_W-1:0]   rs_func;
  logic [N*DATA_W-1:0]   rs_v1;
  logic [N*DATA_W-1:0]   rs_v2;
  logic [N*TAG_W-1:0]    rs_dst;
  logic [N-1:0]          rs_issue;
  logic                  fu_start;
  logic [FUNC_W-1:0]     fu_func;
  logic [DATA_W-1:0]     fu_v1;
  logic [DATA_W-1:0]     fu_v2;
  logic                  fu_done;
  logic [DATA_W-1:0]     fu_result;
  logic                  cdb_req;
  logic [TAG_W-1:0]      cdb_tag;
  logic [DATA_W-1:0]     cdb_value;
  logic                  cdb_grant;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  fu_issue_scheduler #(
    .NUM_RS  (N),
    .RS_IDX_W(RS_IDX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .FUNC_W  (FUNC_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rs_ready (rs_ready),
    .rs_func  (rs_func),
    .rs_v1    (rs_v1),
    .rs_v2    (rs_v2),
    .rs_dst   (rs_dst),
    .rs_issue (rs_issue),
    .fu_start (fu_start),
    .fu_func  (fu_func),
    .fu_v1    (fu_v1),
    .fu_v2    (fu_v2),
    .fu_done  (fu_done),
    .fu_result(fu_result),
    .cdb_req  (cdb_req),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value),
    .cdb_grant(cdb_grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] v1_of(input int i);
    return DATA_W'(i) * 32'h80;
  endfunction

  task automatic load_packets();
    for (int i = 0; i < N; i++) begin
      rs_func[i*FUNC_W +: FUNC_W] = FUNC_W'(i + 1);
      rs_v1[i*DATA_W +: DATA_W]   = v1_of(i);
      rs_v2[i*DATA_W +: DATA_W]   = 32'h1000 + DATA_W'(i);
      rs_dst[i*TAG_W +: TAG_W]    = 6'h20 + TAG_W'(i);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    rs_ready  = '0;
    fu_done   = 1'b0;
    fu_result = '0;
    cdb_grant = 1'b0;
    load_packets();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (rs_issue !== 4'b0000) begin
        miscompares++; $display("FAIL reset_issue: got %b want 0000", rs_issue);
      end
      vectors++;
      if (fu_start !== 1'b0) begin
        miscompares++; $display("FAIL reset_fu_start: got %b want 0", fu_start);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      vectors++;
      if (cdb_req !== 1'b0) begin
        miscompares++; $display("FAIL reset_cdb_req: got %b want 0", cdb_req);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (fu_v1 !== 32'h0 || fu_func !== 5'h0 || fu_v2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fu_data: got %h/%h/%h want 0/0/0", fu_func, fu_v1, fu_v2);
    end
    vectors++;
    if (cdb_tag !== 6'h0 || cdb_value !== 32'h0) begin
      miscompares++; $display("FAIL reset_cdb_data: got %h/%h want 0/0", cdb_tag, cdb_value);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [N-1:0] exp_iss;
    apply_reset();
    rs_ready = 4'b1111;
    for (int op = 0; op < 5; op++) begin
      cdb_grant = (op != 0);
      exp_iss   = 4'b0001 << (op % N);
      @(negedge clk);
      vectors++;
      if (rs_issue !== exp_iss) begin
        miscompares++; $display("FAIL rr_issue op%0d: got %b want %b", op, rs_issue, exp_iss);
      end
      vectors++;
      if ($countones(rs_issue) > 1) begin
        miscompares++; $display("FAIL rr_onehot op%0d: got %b want one-hot", op, rs_issue);
      end
      if (op != 0) begin
        vectors++;
        if (cdb_req !== 1'b1 || cdb_value !== 32'h100 + DATA_W'(op - 1) ||
            cdb_tag !== 6'h20 + TAG_W'((op - 1) % N)) begin
          miscompares++;
          $display("FAIL rr_cdb op%0d: got req=%b tag=%h val=%h want 1/%h/%h", op, cdb_req,
                   cdb_tag, cdb_value, 6'h20 + TAG_W'((op - 1) % N), 32'h100 + DATA_W'(op - 1));
        end
      end
      next_cycle();
      cdb_grant = 1'b0;
      @(negedge clk);
      vectors++;
      if (fu_start !== 1'b1 || fu_v1 !== v1_of(op % N) || fu_func !== FUNC_W'((op % N) + 1)) begin
        miscompares++;
        $display("FAIL rr_fu op%0d: got start=%b v1=%h func=%h want 1/%h/%h", op, fu_start,
                 fu_v1, fu_func, v1_of(op % N), FUNC_W'((op % N) + 1));
      end
      vectors++;
      if (rs_issue !== 4'b0000) begin
        miscompares++; $display("FAIL rr_exec_issue op%0d: got %b want 0000", op, rs_issue);
      end
      next_cycle();
      next_cycle();
      fu_done   = 1'b1;
      fu_result = 32'h100 + DATA_W'(op);
      next_cycle();
      fu_done = 1'b0;
    end
    rs_ready  = '0;
    cdb_grant = 1'b1;
    @(negedge clk);
    vectors++;
    if (cdb_req !== 1'b1 || cdb_value !== 32'h104 || cdb_tag !== 6'h20) begin
      miscompares++;
      $display("FAIL rr_last_cdb: got %b/%h/%h want 1/20/00000104", cdb_req, cdb_tag, cdb_value);
    end
    next_cycle();
    cdb_grant = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cdb_req !== 1'b0) begin
      miscompares++; $display("FAIL rr_idle: got busy=%b req=%b want 0/0", busy, cdb_req);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cdb_stall();
    logic [N-1:0] exp_iss;
    apply_reset();
    rs_ready = 4'b0010;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b0010) begin
      miscompares++; $display("FAIL stall_issue: got %b want 0010", rs_issue);
    end
    next_cycle();
    rs_ready  = 4'b1111;
    fu_done   = 1'b1;  // coincides with fu_start
    fu_result = 32'h30;
    @(negedge clk);
    vectors++;
    if (fu_start !== 1'b1 || rs_issue !== 4'b0000) begin
      miscompares++; $display("FAIL stall_exec: got start=%b iss=%b want 1/0000", fu_start, rs_issue);
    end
    next_cycle();
    fu_done = 1'b0;
    for (int w = 0; w < 4; w++) begin
      cdb_grant = (w == 3);
      exp_iss   = (w == 3) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      vectors++;
      if (cdb_req !== 1'b1 || cdb_tag !== 6'h21 || cdb_value !== 32'h30) begin
        miscompares++;
        $display("FAIL stall_cdb w%0d: got %b/%h/%h want 1/21/00000030", w, cdb_req, cdb_tag,
                 cdb_value);
      end
      vectors++;
      if (rs_issue !== exp_iss) begin
        miscompares++; $display("FAIL stall_issue w%0d: got %b want %b", w, rs_issue, exp_iss);
      end
      next_cycle();
    end
    cdb_grant = 1'b0;
    rs_ready  = '0;
    @(negedge clk);
    vectors++;
    if (cdb_req !== 1'b0 || fu_start !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_after: got req=%b start=%b busy=%b want 0/1/1", cdb_req, fu_start, busy);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    apply_reset();
    rs_ready = 4'b1000;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b1000) begin
      miscompares++; $display("FAIL b2b_first: got %b want 1000", rs_issue);
    end
    next_cycle();
    rs_ready  = '0;
    fu_done   = 1'b1;
    fu_result = 32'h55;
    next_cycle();
    fu_done = 1'b0;
    rs_ready = 4'b1000;
    rs_v1[3*DATA_W +: DATA_W] = 32'hcafe0003;
    cdb_grant = 1'b1;
    @(negedge clk);
    vectors++;
    if (cdb_req !== 1'b1 || rs_issue !== 4'b1000) begin
      miscompares++; $display("FAIL b2b_grant: got req=%b iss=%b want 1/1000", cdb_req, rs_issue);
    end
    next_cycle();
    cdb_grant = 1'b0;
    rs_ready  = '0;
    @(negedge clk);
    vectors++;
    if (fu_start !== 1'b1 || cdb_req !== 1'b0 || busy !== 1'b1 || fu_v1 !== 32'hcafe0003) begin
      miscompares++;
      $display("FAIL b2b_next: got start=%b req=%b busy=%b v1=%h want 1/0/1/cafe0003", fu_start,
               cdb_req, busy, fu_v1);
    end
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush    = 1'b0;
    rs_ready = 4'b1111;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rs_issue !== 4'b0001) begin
      miscompares++; $display("FAIL b2b_rr_wrap: got busy=%b iss=%b want 0/0001", busy, rs_issue);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    apply_reset();
    rs_ready = 4'b0100;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b0100) begin
      miscompares++; $display("FAIL wrap_first: got %b want 0100", rs_issue);
    end
    next_cycle();
    rs_ready = '0;
    fu_done  = 1'b1;
    next_cycle();
    fu_done   = 1'b0;
    cdb_grant = 1'b1;
    next_cycle();
    cdb_grant = 1'b0;
    rs_ready  = 4'b0100;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rs_issue !== 4'b0100) begin
      miscompares++; $display("FAIL wrap_search: got busy=%b iss=%b want 0/0100", busy, rs_issue);
    end
    next_cycle();
    rs_ready = '0;
    fu_done  = 1'b1;
    next_cycle();
    fu_done   = 1'b0;
    cdb_grant = 1'b1;
    next_cycle();
    cdb_grant = 1'b0;
    rs_ready  = 4'b1111;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b1000) begin
      miscompares++; $display("FAIL wrap_ptr: got %b want 1000", rs_issue);
    end
    next_cycle();
    rs_ready = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    apply_reset();
    rs_ready = 4'b0001;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b0001) begin
      miscompares++; $display("FAIL flush_issue: got %b want 0001", rs_issue);
    end
    next_cycle();
    rs_ready = '0;
    flush    = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || fu_start !== 1'b1) begin
      miscompares++; $display("FAIL flush_exec: got busy=%b start=%b want 1/1", busy, fu_start);
    end
    next_cycle();
    flush     = 1'b0;
    fu_done   = 1'b1;
    fu_result = 32'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || cdb_req !== 1'b0 || fu_start !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_idle c%0d: got busy=%b req=%b start=%b want 0/0/0", c, busy, cdb_req,
                 fu_start);
      end
      next_cycle();
      fu_done = 1'b0;
    end
    rs_ready = 4'b1111;
    flush    = 1'b1;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b0000) begin
      miscompares++; $display("FAIL flush_no_issue: got %b want 0000", rs_issue);
    end
    next_cycle();
    flush    = 1'b0;
    rs_ready = '0;
    @(negedge clk);
    vectors++;
    if (fu_start !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_no_start: got start=%b busy=%b want 0/0", fu_start, busy);
    end
    next_cycle();
    rs_ready = 4'b1111;
    @(negedge clk);
    vectors++;
    if (rs_issue !== 4'b0010) begin
      miscompares++; $display("FAIL flush_keeps_ptr: got %b want 0010", rs_issue);
    end
    next_cycle();
    rs_ready = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_in_wb();
    apply_reset();
    rs_ready = 4'b0100;
    next_cycle();
    rs_ready  = '0;
    fu_done   = 1'b1;
    fu_result = 32'h99;
    next_cycle();
    fu_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (cdb_req !== 1'b1 || cdb_tag !== 6'h22) begin
      miscompares++; $display("FAIL rwb_setup: got req=%b tag=%h want 1/22", cdb_req, cdb_tag);
    end
    reset = 1'b1;
    next_cycle();
    reset    = 1'b0;
    rs_ready = 4'b1111;
    @(negedge clk);
    vectors++;
    if (cdb_req !== 1'b0 || busy !== 1'b0 || cdb_tag !== 6'h0 || fu_v1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rwb_values: got req=%b busy=%b tag=%h v1=%h want 0/0/00/0", cdb_req, busy,
               cdb_tag, fu_v1);
    end
    vectors++;
    if (rs_issue !== 4'b0001) begin
      miscompares++; $display("FAIL rwb_ptr: got %b want 0001", rs_issue);
    end
    next_cycle();
    rs_ready = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: scheduler phase (0 idle, 1 executing, 2 broadcasting) plus
  // the values the rules say must be visible.
  int                m_state;
  int                m_rr;
  logic              m_start;
  logic [FUNC_W-1:0] m_func;
  logic [DATA_W-1:0] m_v1;
  logic [DATA_W-1:0] m_v2;
  logic [TAG_W-1:0]  m_dst;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_val;

  function automatic int pick(input logic [N-1:0] rdy, input int rr);
    for (int k = 0; k < N; k++) begin
      if (rdy[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_state = 0; m_rr = 0; m_start = 1'b0;
    m_func = '0; m_v1 = '0; m_v2 = '0; m_dst = '0; m_tag = '0; m_val = '0;
  endtask

  task automatic test_random();
    int           w;
    logic [N-1:0] exp_iss;
    apply_reset();
    model_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      rs_ready  = N'($urandom);
      fu_done   = ($urandom_range(0, 2) == 0);
      fu_result = $urandom;
      cdb_grant = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        rs_func[i*FUNC_W +: FUNC_W] = FUNC_W'($urandom);
        rs_v1[i*DATA_W +: DATA_W]   = $urandom;
        rs_v2[i*DATA_W +: DATA_W]   = $urandom;
        rs_dst[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
      end

      w = -1;
      if (!reset && !flush && (m_state == 0 || (m_state == 2 && cdb_grant))) begin
        w = pick(rs_ready, m_rr);
      end
      exp_iss = '0;
      if (w >= 0) exp_iss[w] = 1'b1;

      @(negedge clk);
      vectors++;
      if (rs_issue !== exp_iss) begin
        miscompares++; $display("FAIL rand_issue c%0d: got %b want %b", cyc, rs_issue, exp_iss);
      end
      vectors++;
      if (fu_start !== m_start) begin
        miscompares++; $display("FAIL rand_start c%0d: got %b want %b", cyc, fu_start, m_start);
      end
      vectors++;
      if (busy !== (m_state != 0) || cdb_req !== (m_state == 2)) begin
        miscompares++;
        $display("FAIL rand_status c%0d: got busy=%b req=%b want %b/%b", cyc, busy, cdb_req,
                 m_state != 0, m_state == 2);
      end
      vectors++;
      if (fu_func !== m_func || fu_v1 !== m_v1 || fu_v2 !== m_v2) begin
        miscompares++;
        $display("FAIL rand_fu c%0d: got %h/%h/%h want %h/%h/%h", cyc, fu_func, fu_v1, fu_v2,
                 m_func, m_v1, m_v2);
      end
      if (m_state == 2) begin
        vectors++;
        if (cdb_tag !== m_tag || cdb_value !== m_val) begin
          miscompares++;
          $display("FAIL rand_cdb c%0d: got %h/%h want %h/%h", cyc, cdb_tag, cdb_value, m_tag,
                   m_val);
        end
      end

      if (reset) begin
        model_clear();
      end else if (flush) begin
        m_state = 0;
        m_start = 1'b0;
      end else begin
        m_start = 1'b0;
        if (w >= 0) begin
          m_func  = rs_func[w*FUNC_W +: FUNC_W];
          m_v1    = rs_v1[w*DATA_W +: DATA_W];
          m_v2    = rs_v2[w*DATA_W +: DATA_W];
          m_dst   = rs_dst[w*TAG_W +: TAG_W];
          m_rr    = (w + 1) % N;
          m_start = 1'b1;
          m_state = 1;
        end else if (m_state == 1 && fu_done) begin
          m_tag   = m_dst;
          m_val   = fu_result;
          m_state = 2;
        end else if (m_state == 2 && cdb_grant) begin
          m_state = 0;
        end
      end
      next_cycle();
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_cdb_stall();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_in_wb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
Shares one non-pipelined functional unit (FU) among NUM_RS reservation stations. Each cycle it picks one ready station in round-robin order and pulses that station's issue line. It latches the selected operand packet and starts the FU. It then holds the FU result and requests the common data bus (CDB) until it receives a grant. It sits between the reservation stations' insn_ready/issue handshake and the FU/CDB writeback path.

Parameters:
NUM_RS, 4, number of requesting reservation stations (>=2)
RS_IDX_W, 2, clog2(NUM_RS)
TAG_W, 6, ROB tag width (`ROB_TAG_LEN)
DATA_W, 32, operand/result width (`XLEN)
FUNC_W, 5, ALU_FUNC encoding width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash: abandon in-flight op, return to IDLE
rs_ready  in  NUM_RS  per-station insn_ready
rs_func  in  NUM_RS*FUNC_W  per-station func_out, flattened, station i at [i*FUNC_W +: FUNC_W]
rs_v1  in  NUM_RS*DATA_W  per-station v1_out, flattened
rs_v2  in  NUM_RS*DATA_W  per-station v2_out, flattened
rs_dst  in  NUM_RS*TAG_W  per-station dst_tag, flattened
rs_issue  out  NUM_RS  one-hot issue pulse to selected station
fu_start  out  1  one-cycle start pulse to FU
fu_func  out  FUNC_W  latched function
fu_v1  out  DATA_W  latched operand 1
fu_v2  out  DATA_W  latched operand 2
fu_done  in  1  FU result valid (single-cycle pulse)
fu_result  in  DATA_W  FU result, sampled when fu_done=1
cdb_req  out  1  request CDB broadcast
cdb_tag  out  TAG_W  tag to broadcast
cdb_value  out  DATA_W  value to broadcast
cdb_grant  in  1  CDB grant; broadcast completes this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, rs_issue=0, fu_start=0, cdb_req=0, busy=0. All data registers (fu_func/v1/v2, cdb_tag/value, held dst) are 0.
- FSM states: IDLE, EXEC, WB.
- Selection is combinational: the first i with rs_ready[i]=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... NUM_RS-1, 0, ...).
- Issue can happen from IDLE, or from WB in the same cycle cdb_grant=1 (back-to-back).
- On an issue cycle, with winner w:
  - rs_issue[w]=1 for exactly that cycle.
  - The packet of w is registered into fu_func/fu_v1/fu_v2 and the held dst.
  - fu_start=1 in the following cycle.
  - rr_ptr <= (w+1) mod NUM_RS; next state is EXEC.
  - If no station is ready, rs_issue=0, rr_ptr is unchanged, and the next state is IDLE.
- EXEC: rs_issue=0 and fu_start is low after its pulse.
  - fu_done=1 captures fu_result into cdb_value and held dst into cdb_tag; next state is WB.
  - fu_done arriving in the same cycle as fu_start is legal and is captured.
- WB: cdb_req=1; cdb_tag/cdb_value are stable while cdb_req=1 and grant is absent.
  - cdb_grant=1: cdb_req drops next cycle. Go to EXEC if a new issue happened this cycle, else IDLE.
- cdb_grant while not in WB is ignored. fu_done outside EXEC is ignored.
- flush (priority below reset, above all else): next state IDLE, cdb_req=0, no rs_issue that cycle, fu_start suppressed. rr_ptr is kept. Data registers are kept (don't-care).
- Reset mid-operation: immediate return to the reset values above, including rr_ptr=0.
- At most one rs_issue bit is ever set.
- Throughput is 1 op per (FU latency + CDB wait + 1) cycles.

Test Plan:
- Reset then all rs_ready=0 for 5 cycles -> rs_issue=0, fu_start=0, busy=0, cdb_req=0.
- rs_ready=4'b1111, fu_done 2 cycles after each fu_start, cdb_grant on first cycle of each cdb_req -> issue order stations 0,1,2,3,0. Each rs_issue is one-hot. fu_v1 of each op equals the issued station's rs_v1, e.g. station 2 v1=32'h00000100.
- Station 1 dst=6'h21, fu_result=32'h00000030, cdb_grant held low 3 cycles -> cdb_req high 4 cycles, cdb_tag=6'h21, cdb_value=32'h00000030 stable throughout. No new rs_issue until the grant cycle.
- Back-to-back: cdb_grant=1 while rs_ready[3]=1 -> rs_issue[3] in the grant cycle, fu_start next cycle, cdb_req low next cycle, state EXEC.
- Only rs_ready[2]=1 with rr_ptr=3 -> wrap search selects station 2, and rr_ptr becomes 3.
- flush asserted in EXEC, then fu_done next cycle -> returns to IDLE, cdb_req stays 0. Separately, reset in WB -> cdb_req=0 and rr_ptr=0 the next cycle.
